ledcomm_uart_bridge: RTL and testbench

- Parametrised bidirectional byte bridge between a UART-style endpoint (side A) and a Ledcomm-style endpoint (side B).
- Succeeds the fixed two-FSM flow glue: adds per-direction FIFO buffering of configurable depth, a configurable pop-settle holdoff, a selectable link-down policy (hold or drop), and drop/occupancy statistics.
- Sits at top level between buart and ledcommflow.
- Also drives the three sigma-delta status LED channels.

---
 rtl/ledcomm_uart_bridge.sv | 256 +++++++++++++++++++++++++
 tb/tb_ledcomm_uart_bridge.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ledcomm_uart_bridge.sv
// ---------------------------------------------------------------------------
// ledcomm_uart_bridge
//    Bidirectional byte bridge between a UART-style endpoint (side A) and a
//    Ledcomm-style endpoint (side B).  Each direction has an ingress FSM that
//    pops the source into a circular FIFO, and an egress FSM that writes the
//    FIFO head to the destination.  The A->B direction is gated by the Ledcomm
//    link; while the link is down bytes are either held or dropped.  Three
//    sigma-delta channels drive the status LEDs.
//
// Ports (top):
//    clk, resetq                 clock, asynchronous active-low reset
//    a_valid/a_rx_data/a_rd      side A receiver handshake (pop pulse)
//    a_busy/a_wr/a_tx_data       side A transmitter handshake (write pulse)
//    b_*                         same as side A, for side B
//    b_link                      Ledcomm link up
//    a2b_level, b2a_level        FIFO occupancy per direction
//    drop_count                  saturating count of discarded A->B bytes
//    sdm_red/green/blue_out      sigma-delta LED drive bits
// ---------------------------------------------------------------------------

// One direction: ingress FSM -> circular FIFO -> egress FSM.
module ledcomm_uart_bridge_dir #(
   parameter int DATA_W      = 8,
   parameter int DEPTH_LOG2  = 4,
   parameter int HOLDOFF     = 2,
   parameter bit DROP_NOLINK = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              src_valid,
   input  logic [DATA_W-1:0] src_rx_data,
   output logic              src_rd,
   input  logic              dst_busy,
   output logic              dst_wr,
   output logic [DATA_W-1:0] dst_tx_data,
   input  logic              gate,
   output logic [DEPTH_LOG2:0] level,
   output logic              drop_pulse
);
   localparam logic [3:0] HOLD_LAST = 4'(HOLDOFF - 1);

   typedef enum logic [1:0] {IN_IDLE, IN_CAP, IN_HOLD} in_state_t;
   typedef enum logic [1:0] {EG_IDLE, EG_SEND, EG_HOLD} eg_state_t;

   in_state_t         r_in_state;
   eg_state_t         r_eg_state;
   logic [3:0]        r_in_cnt;
   logic [3:0]        r_eg_cnt;
   logic              r_src_rd;
   logic              r_dst_wr;
   logic [DATA_W-1:0] r_dst_tx_data;
   logic [DEPTH_LOG2:0] r_wptr;
   logic [DEPTH_LOG2:0] r_rptr;
   logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;
   logic w_drop_now;

   // Extra pointer MSB distinguishes full from empty when the low bits match.
   assign w_full  = (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) &&
                    (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);
   assign w_empty = (r_wptr == r_rptr);
   assign w_push  = (r_in_state == IN_CAP);
   // Discarding happens straight from IDLE so one byte goes per 1+HOLDOFF cycles.
   assign w_drop_now = DROP_NOLINK && !gate && !w_empty && (r_eg_state == EG_IDLE);
   assign w_pop   = (r_eg_state == EG_SEND) || w_drop_now;

   assign src_rd      = r_src_rd;
   assign dst_wr      = r_dst_wr;
   assign dst_tx_data = r_dst_tx_data;
   assign level       = r_wptr - r_rptr;
   assign drop_pulse  = w_drop_now;

   // Ingress: capture the source byte, then wait HOLDOFF cycles so the source
   // has retired it before valid is sampled again.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_state <= IN_IDLE;
         r_in_cnt   <= '0;
         r_src_rd   <= 1'b0;
      end else begin
         r_src_rd <= 1'b0;
         case (r_in_state)
            IN_IDLE: if (src_valid && !w_full) r_in_state <= IN_CAP;
            IN_CAP: begin
               r_src_rd   <= 1'b1;
               r_in_cnt   <= '0;
               r_in_state <= IN_HOLD;
            end
            IN_HOLD: begin
               if (r_in_cnt == HOLD_LAST) r_in_state <= IN_IDLE;
               else r_in_cnt <= r_in_cnt + 4'd1;
            end
            default: r_in_state <= IN_IDLE;
         endcase
      end
   end

   // FIFO storage carries no reset; occupancy is defined by the pointers alone.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= src_rx_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   // Egress: registered data and strobe, so tx_data is stable with the write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_eg_state    <= EG_IDLE;
         r_eg_cnt      <= '0;
         r_dst_wr      <= 1'b0;
         r_dst_tx_data <= '0;
      end else begin
         r_dst_wr <= 1'b0;
         case (r_eg_state)
            EG_IDLE: begin
               if (w_drop_now) begin
                  r_eg_cnt   <= '0;
                  r_eg_state <= EG_HOLD;
               end else if (!w_empty && !dst_busy && gate) begin
                  r_eg_state <= EG_SEND;
               end
            end
            EG_SEND: begin
               r_dst_wr      <= 1'b1;
               r_dst_tx_data <= r_mem[r_rptr[DEPTH_LOG2-1:0]];
               r_eg_cnt      <= '0;
               r_eg_state    <= EG_HOLD;
            end
            EG_HOLD: begin
               if (r_eg_cnt == HOLD_LAST) r_eg_state <= EG_IDLE;
               else r_eg_cnt <= r_eg_cnt + 4'd1;
            end
            default: r_eg_state <= EG_IDLE;
         endcase
      end
   end
endmodule

module ledcomm_uart_bridge #(
   parameter int          DATA_W      = 8,
   parameter int          DEPTH_LOG2  = 4,
   parameter int          HOLDOFF     = 2,
   parameter bit          DROP_NOLINK = 1'b0,
   parameter logic [15:0] FLASH       = 16'h8000
) (
   input  logic                clk,
   input  logic                resetq,
   input  logic                a_valid,
   input  logic [DATA_W-1:0]   a_rx_data,
   output logic                a_rd,
   input  logic                a_busy,
   output logic                a_wr,
   output logic [DATA_W-1:0]   a_tx_data,
   input  logic                b_valid,
   input  logic [DATA_W-1:0]   b_rx_data,
   output logic                b_rd,
   input  logic                b_busy,
   output logic                b_wr,
   output logic [DATA_W-1:0]   b_tx_data,
   input  logic                b_link,
   output logic [DEPTH_LOG2:0] a2b_level,
   output logic [DEPTH_LOG2:0] b2a_level,
   output logic [7:0]          drop_count,
   output logic                sdm_red_out,
   output logic                sdm_green_out,
   output logic                sdm_blue_out
);
   logic [1:0]  r_rst_sync;
   logic        w_rst_n;
   logic        w_a2b_drop;
   logic        w_b2a_drop;
   logic [7:0]  r_drop_count;
   logic [15:0] r_red_lvl, r_blue_lvl;
   logic [15:0] r_red_phase, r_green_phase, r_blue_phase;
   logic        r_sdm_red, r_sdm_green, r_sdm_blue;
   logic [15:0] w_green_lvl;
   logic [16:0] w_red_sum, w_green_sum, w_blue_sum;

   // Reset asserts immediately but releases on a clock edge.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) r_rst_sync <= 2'b00;
      else         r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   ledcomm_uart_bridge_dir #(
      .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .HOLDOFF(HOLDOFF), .DROP_NOLINK(DROP_NOLINK)
   ) u_a2b (
      .clk(clk), .rst_n(w_rst_n),
      .src_valid(a_valid), .src_rx_data(a_rx_data), .src_rd(a_rd),
      .dst_busy(b_busy), .dst_wr(b_wr), .dst_tx_data(b_tx_data),
      .gate(b_link), .level(a2b_level), .drop_pulse(w_a2b_drop)
   );

   // The B->A path is never gated, so it can never discard.
   ledcomm_uart_bridge_dir #(
      .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .HOLDOFF(HOLDOFF), .DROP_NOLINK(1'b0)
   ) u_b2a (
      .clk(clk), .rst_n(w_rst_n),
      .src_valid(b_valid), .src_rx_data(b_rx_data), .src_rd(b_rd),
      .dst_busy(a_busy), .dst_wr(a_wr), .dst_tx_data(a_tx_data),
      .gate(1'b1), .level(b2a_level), .drop_pulse(w_b2a_drop)
   );

   // Saturating count of discarded bytes.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) r_drop_count <= '0;
      else if ((w_a2b_drop || w_b2a_drop) && (r_drop_count != 8'hFF))
         r_drop_count <= r_drop_count + 8'd1;
   end
   assign drop_count = r_drop_count;

   // LED channels: a flash loads a level that bleeds off by one per clock; the
   // accumulator carry is a pulse density proportional to the level.
   assign w_green_lvl = b_link ? 16'h0010 : 16'h1000;
   assign w_red_sum   = {1'b0, r_red_phase}   + {1'b0, r_red_lvl};
   assign w_green_sum = {1'b0, r_green_phase} + {1'b0, w_green_lvl};
   assign w_blue_sum  = {1'b0, r_blue_phase}  + {1'b0, r_blue_lvl};

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_red_lvl     <= '0;
         r_blue_lvl    <= '0;
         r_red_phase   <= '0;
         r_green_phase <= '0;
         r_blue_phase  <= '0;
         r_sdm_red     <= 1'b0;
         r_sdm_green   <= 1'b0;
         r_sdm_blue    <= 1'b0;
      end else begin
         if (b_wr)                 r_red_lvl <= FLASH;
         else if (r_red_lvl != 0)  r_red_lvl <= r_red_lvl - 16'd1;
         if (a_wr)                 r_blue_lvl <= FLASH;
         else if (r_blue_lvl != 0) r_blue_lvl <= r_blue_lvl - 16'd1;
         {r_sdm_red,   r_red_phase}   <= w_red_sum;
         {r_sdm_green, r_green_phase} <= w_green_sum;
         {r_sdm_blue,  r_blue_phase}  <= w_blue_sum;
      end
   end

   assign sdm_red_out   = r_sdm_red;
   assign sdm_green_out = r_sdm_green;
   assign sdm_blue_out  = r_sdm_blue;
endmodule

// File: tb/tb_ledcomm_uart_bridge.sv
// ---------------------------------------------------------------------------
// tb_ledcomm_uart_bridge
//    Directed bench for ledcomm_uart_bridge.  Instance 0 uses the default
//    parameters (hold on link down, 16-deep FIFOs); instance 1 uses 4-deep
//    FIFOs with drop-on-link-down.  Endpoint models pop a byte queue on each
//    rd pulse and record every byte written out.
// ---------------------------------------------------------------------------
module tb_ledcomm_uart_bridge;
   logic clk = 1'b0;
   logic resetq;
   int   cyc = 0;
   int   checkCount = 0;
   int   errorCount = 0;

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- instance 0 signals ----------------
   logic       a_valid0 = 1'b0, b_valid0 = 1'b0;
   logic [7:0] a_rx0 = '0, b_rx0 = '0;
   logic       a_busy0, b_busy0, b_link0;
   logic       a_rd0, b_rd0, a_wr0, b_wr0;
   logic [7:0] a_tx0, b_tx0;
   logic [4:0] a2b0, b2a0;
   logic [7:0] drop0;
   logic       red0, green0, blue0;

   // ---------------- instance 1 signals ----------------
   logic       a_valid1 = 1'b0, b_valid1 = 1'b0;
   logic [7:0] a_rx1 = '0, b_rx1 = '0;
   logic       a_busy1, b_busy1, b_link1;
   logic       a_rd1, b_rd1, a_wr1, b_wr1;
   logic [7:0] a_tx1, b_tx1;
   logic [2:0] a2b1, b2a1;
   logic [7:0] drop1;
   logic       red1, green1, blue1;

   ledcomm_uart_bridge u_dut0 (
      .clk(clk), .resetq(resetq),
      .a_valid(a_valid0), .a_rx_data(a_rx0), .a_rd(a_rd0),
      .a_busy(a_busy0), .a_wr(a_wr0), .a_tx_data(a_tx0),
      .b_valid(b_valid0), .b_rx_data(b_rx0), .b_rd(b_rd0),
      .b_busy(b_busy0), .b_wr(b_wr0), .b_tx_data(b_tx0),
      .b_link(b_link0), .a2b_level(a2b0), .b2a_level(b2a0), .drop_count(drop0),
      .sdm_red_out(red0), .sdm_green_out(green0), .sdm_blue_out(blue0)
   );

   ledcomm_uart_bridge #(.DEPTH_LOG2(2), .DROP_NOLINK(1'b1)) u_dut1 (
      .clk(clk), .resetq(resetq),
      .a_valid(a_valid1), .a_rx_data(a_rx1), .a_rd(a_rd1),
      .a_busy(a_busy1), .a_wr(a_wr1), .a_tx_data(a_tx1),
      .b_valid(b_valid1), .b_rx_data(b_rx1), .b_rd(b_rd1),
      .b_busy(b_busy1), .b_wr(b_wr1), .b_tx_data(b_tx1),
      .b_link(b_link1), .a2b_level(a2b1), .b2a_level(b2a1), .drop_count(drop1),
      .sdm_red_out(red1), .sdm_green_out(green1), .sdm_blue_out(blue1)
   );

   // Endpoint model state
   logic [7:0] qA0[$], qB0[$], rxA0[$], rxB0[$];
   logic [7:0] qA1[$], qB1[$], rxA1[$], rxB1[$];
   int rdA0 = 0, rdB0 = 0, wrA0 = 0, wrB0 = 0;
   int rdA1 = 0, rdB1 = 0, wrA1 = 0, wrB1 = 0;
   int rdA0Cyc = -1, wrB0Cyc = -1, gapB0 = 1000;
   int lvlRdA0 = -1, lvlWrB0 = -1;
   int redCnt0 = 0, greenCnt0 = 0, blueCnt0 = 0;

   // Instance 0 endpoints: sample strobes mid-cycle, away from the active edge.
   initial begin
      logic [7:0] dummy;
      forever begin
         @(negedge clk);
         if (a_rd0 && qA0.size() > 0) dummy = qA0.pop_front();
         if (b_rd0 && qB0.size() > 0) dummy = qB0.pop_front();
         a_valid0 = (qA0.size() > 0);
         a_rx0    = (qA0.size() > 0) ? qA0[0] : 8'h00;
         b_valid0 = (qB0.size() > 0);
         b_rx0    = (qB0.size() > 0) ? qB0[0] : 8'h00;
         if (a_rd0) begin rdA0++; rdA0Cyc = cyc; lvlRdA0 = int'(a2b0); end
         if (b_rd0) rdB0++;
         if (a_wr0) begin wrA0++; rxA0.push_back(a_tx0); end
         if (b_wr0) begin
            wrB0++;
            rxB0.push_back(b_tx0);
            if (wrB0Cyc >= 0 && (cyc - wrB0Cyc) < gapB0) gapB0 = cyc - wrB0Cyc;
            wrB0Cyc = cyc;
            lvlWrB0 = int'(a2b0);
         end
         if (red0)   redCnt0++;
         if (green0) greenCnt0++;
         if (blue0)  blueCnt0++;
      end
   end

   // Instance 1 endpoints
   initial begin
      logic [7:0] dummy;
      forever begin
         @(negedge clk);
         if (a_rd1 && qA1.size() > 0) dummy = qA1.pop_front();
         if (b_rd1 && qB1.size() > 0) dummy = qB1.pop_front();
         a_valid1 = (qA1.size() > 0);
         a_rx1    = (qA1.size() > 0) ? qA1[0] : 8'h00;
         b_valid1 = (qB1.size() > 0);
         b_rx1    = (qB1.size() > 0) ? qB1[0] : 8'h00;
         if (a_rd1) rdA1++;
         if (b_rd1) rdB1++;
         if (a_wr1) begin wrA1++; rxA1.push_back(a_tx1); end
         if (b_wr1) begin wrB1++; rxB1.push_back(b_tx1); end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(negedge clk);
      #1;
   endtask

   initial begin
      int s, e, wrA0Base, wrB0Base;
      resetq  = 1'b0;
      a_busy0 = 1'b0; b_busy0 = 1'b0; b_link0 = 1'b1;
      a_busy1 = 1'b0; b_busy1 = 1'b0; b_link1 = 1'b1;
      applyStimulus(3);

      // Reset state
      checkOutput("rst_a2b_level", a2b0, 0);
      checkOutput("rst_b2a_level", b2a0, 0);
      checkOutput("rst_strobes", {a_rd0, b_rd0, a_wr0, b_wr0}, 0);
      checkOutput("rst_tx_data", {a_tx0, b_tx0}, 0);
      checkOutput("rst_drop", drop1, 0);
      checkOutput("rst_sdm", {red0, green0, blue0}, 0);

      resetq = 1'b1;
      applyStimulus(5);

      // Single byte A->B, link up
      qA0.push_back(8'h5A);
      applyStimulus(20);
      checkOutput("single_rd_count", rdA0, 1);
      checkOutput("single_wr_count", wrB0, 1);
      checkOutput("single_data", (rxB0.size() > 0) ? rxB0[0] : 8'hEE, 8'h5A);
      checkOutput("single_latency", wrB0Cyc - rdA0Cyc, 2);
      checkOutput("single_level_after_push", lvlRdA0, 1);
      checkOutput("single_level_at_wr", lvlWrB0, 0);
      checkOutput("single_level_end", a2b0, 0);
      checkOutput("single_red_flash", (redCnt0 > 0), 1);
      checkOutput("single_blue_idle", blueCnt0, 0);
      rxB0.delete();

      // Link down, hold policy; green runs at 0x1000 (one carry per 16 clocks)
      b_link0 = 1'b0;
      wrB0Base = wrB0;
      for (int i = 1; i <= 5; i++) qA0.push_back(8'(i));
      applyStimulus(4);
      s = greenCnt0;
      applyStimulus(64);
      e = greenCnt0;
      checkOutput("green_linkdown_rate", e - s, 4);
      checkOutput("hold_no_wr", wrB0 - wrB0Base, 0);
      checkOutput("hold_level", a2b0, 5);

      wrB0Cyc = -1;
      gapB0   = 1000;
      b_link0 = 1'b1;
      applyStimulus(60);
      checkOutput("hold_release_count", rxB0.size(), 5);
      for (int i = 0; i < 5; i++)
         checkOutput($sformatf("hold_byte%0d", i), (rxB0.size() > i) ? rxB0[i] : 8'hEE, 8'(i + 1));
      checkOutput("hold_min_gap", (gapB0 >= 3), 1);
      checkOutput("hold_level_end", a2b0, 0);

      // Both directions concurrently with distinct patterns
      rxA0.delete();
      rxB0.delete();
      for (int i = 0; i < 20; i++) begin
         qA0.push_back(8'(8'h20 + i));
         qB0.push_back(8'(8'hA0 + i));
      end
      applyStimulus(200);
      checkOutput("dual_a2b_count", rxB0.size(), 20);
      checkOutput("dual_b2a_count", rxA0.size(), 20);
      for (int i = 0; i < 20; i++) begin
         checkOutput($sformatf("dual_a2b_byte%0d", i), (rxB0.size() > i) ? rxB0[i] : 8'hEE, 8'(8'h20 + i));
         checkOutput($sformatf("dual_b2a_byte%0d", i), (rxA0.size() > i) ? rxA0[i] : 8'hEE, 8'(8'hA0 + i));
      end
      checkOutput("dual_blue_flash", (blueCnt0 > 0), 1);

      // Instance 1: drop on link down
      b_link1 = 1'b0;
      for (int i = 0; i < 3; i++) qA1.push_back(8'(8'h40 + i));
      applyStimulus(30);
      checkOutput("drop3_no_wr", wrB1, 0);
      checkOutput("drop3_count", drop1, 3);
      checkOutput("drop3_level", a2b1, 0);
      for (int i = 0; i < 300; i++) qA1.push_back(8'(i));
      applyStimulus(1400);
      checkOutput("drop_sat_count", drop1, 255);
      checkOutput("drop_sat_level", a2b1, 0);
      checkOutput("drop_sat_no_wr", wrB1, 0);

      // Instance 1: B->A backpressure with 4-deep FIFO (ungated by link)
      a_busy1 = 1'b1;
      for (int i = 1; i <= 6; i++) qB1.push_back(8'(i));
      applyStimulus(60);
      checkOutput("full_rd_count", rdB1, 4);
      checkOutput("full_level", b2a1, 4);
      checkOutput("full_no_wr", wrA1, 0);
      a_busy1 = 1'b0;
      applyStimulus(100);
      checkOutput("drain_rd_count", rdB1, 6);
      checkOutput("drain_count", rxA1.size(), 6);
      for (int i = 0; i < 6; i++)
         checkOutput($sformatf("drain_byte%0d", i), (rxA1.size() > i) ? rxA1[i] : 8'hEE, 8'(i + 1));
      checkOutput("drain_level", b2a1, 0);

      // Asynchronous reset with both FIFOs at level 3
      a_busy0 = 1'b1;
      b_busy0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         qA0.push_back(8'(8'h31 + i));
         qB0.push_back(8'(8'hC1 + i));
      end
      applyStimulus(30);
      checkOutput("pre_rst_a2b", a2b0, 3);
      checkOutput("pre_rst_b2a", b2a0, 3);
      wrA0Base = wrA0;
      wrB0Base = wrB0;
      @(negedge clk);
      #2 resetq = 1'b0;
      #1;
      checkOutput("async_rst_a2b", a2b0, 0);
      checkOutput("async_rst_b2a", b2a0, 0);
      checkOutput("async_rst_strobes", {a_rd0, b_rd0, a_wr0, b_wr0}, 0);
      checkOutput("async_rst_drop", drop1, 0);
      applyStimulus(3);
      resetq  = 1'b1;
      a_busy0 = 1'b0;
      b_busy0 = 1'b0;
      applyStimulus(50);
      checkOutput("post_rst_no_a_wr", wrA0 - wrA0Base, 0);
      checkOutput("post_rst_no_b_wr", wrB0 - wrB0Base, 0);
      checkOutput("post_rst_levels", {a2b0, b2a0}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end
endmodule
